csa_result_accumulator: RTL and testbench

CSA_RESULT_ACCUMULATOR -- requirements
Module: csa_result_accumulator

---
 rtl/csa_result_accumulator.sv | 104 ++++++++++
 tb/tb_csa_result_accumulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_result_accumulator.sv
// Accumulates a run of carry-save adder results into a wrapping total
// with a sticky overflow flag and a valid/ready result hand-off.
module csa_result_accumulator #(
  parameter int IN_W  = 6,
  parameter int ACC_W = 12,
  parameter int CNT_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_i,
  input  logic [IN_W-2:0]   S_i,
  input  logic              C_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [ACC_W-1:0]  acc_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] num_q;
  logic             ovf;

  logic             xfer;
  logic             last;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W:0]   sum;

  assign xfer    = (state == ACCUM) && valid_i;
  assign cnt_inc = cnt + 1'b1;
  assign last    = (cnt_inc == num_q);

  // One extra bit on top catches the wrap past 2^ACC_W.
  assign sum = {1'b0, acc} +
               {{(ACC_W + 1 - IN_W){1'b0}}, C_i, S_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = (num_i != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (xfer && last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc   <= '0;
      cnt   <= '0;
      num_q <= '0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      if (start_i) begin
        acc   <= '0;
        cnt   <= '0;
        num_q <= num_i;
        ovf   <= 1'b0;
      end
    end else if (xfer) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt_inc;
      if (sum[ACC_W]) begin
        ovf <= 1'b1;
      end
    end
  end

  assign ready_o     = (state == ACCUM);
  assign out_valid_o = (state == DONE);
  assign acc_o       = acc;
  assign ovf_o       = ovf;

endmodule

// File: tb/tb_csa_result_accumulator.sv
// Directed bench: default build plus a 10-bit accumulator build
// sharing the same stimulus.
module tb_csa_result_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  num;
  logic [4:0]  s;
  logic        c;
  logic        valid;
  logic        out_ready;

  logic        ready;
  logic [11:0] acc;
  logic        out_valid;
  logic        ovf;

  logic        ready10;
  logic [9:0]  acc10;
  logic        out_valid10;
  logic        ovf10;

  int vectors = 0;
  int errors  = 0;

  csa_result_accumulator dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .num_i      (num),
    .S_i        (s),
    .C_i        (c),
    .valid_i    (valid),
    .ready_o    (ready),
    .acc_o      (acc),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .ovf_o      (ovf)
  );

  csa_result_accumulator #(.ACC_W(10)) dut10 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .num_i      (num),
    .S_i        (s),
    .C_i        (c),
    .valid_i    (valid),
    .ready_o    (ready10),
    .acc_o      (acc10),
    .out_valid_o(out_valid10),
    .out_ready_i(out_ready),
    .ovf_o      (ovf10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v);
    {c, s} = v[5:0];
  endtask

  task automatic begin_run(input int n);
    num   = n[4:0];
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num       = '0;
    s         = '0;
    c         = 1'b0;
    valid     = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_acc", acc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready", ready, 0);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", ready, 0);

    // three results, back to back
    begin_run(3);
    chk("r1_ready", ready, 1);
    valid = 1'b1;
    drive(31); step();
    drive(5);  step();
    drive(60); step();
    valid = 1'b0;
    chk("r1_out_valid", out_valid, 1);
    chk("r1_acc", acc, 96);
    chk("r1_ready_done", ready, 0);
    consume();
    chk("r1_idle_valid", out_valid, 0);
    chk("r1_idle_hold", acc, 96);

    // gaps between results
    begin_run(2);
    valid = 1'b1;
    drive(10); step();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r2_gap_ready", ready, 1);
      chk("r2_gap_acc", acc, 10);
    end
    valid = 1'b1;
    drive(20); step();
    valid = 1'b0;
    chk("r2_out_valid", out_valid, 1);
    chk("r2_acc", acc, 30);
    consume();

    // 31 x 60 against both accumulator widths
    begin_run(31);
    valid = 1'b1;
    drive(60);
    for (int i = 0; i < 31; i++) step();
    valid = 1'b0;
    chk("r3_out_valid", out_valid, 1);
    chk("r3_acc12", acc, 1860);
    chk("r3_ovf12", ovf, 0);
    chk("r3_out_valid10", out_valid10, 1);
    chk("r3_acc10", acc10, 836);
    chk("r3_ovf10", ovf10, 1);
    consume();
    chk("r3_ovf10_sticky", ovf10, 1);

    // DONE holds until consumed; start ignored there
    begin_run(1);
    chk("r4_ovf10_clear", ovf10, 0);
    valid = 1'b1;
    drive(9); step();
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      num   = '0;
      step();
      chk("r4_hold_valid", out_valid, 1);
      chk("r4_hold_acc", acc, 9);
    end
    start = 1'b0;
    consume();
    chk("r4_idle_valid", out_valid, 0);
    chk("r4_idle_ready", ready, 0);
    chk("r4_idle_acc", acc, 9);

    // asynchronous reset mid-run
    begin_run(4);
    valid = 1'b1;
    drive(5); step();
    step();
    valid = 1'b0;
    chk("r5_partial", acc, 10);
    rst_n = 1'b0;
    #1;
    chk("r5_rst_acc", acc, 0);
    chk("r5_rst_ready", ready, 0);
    chk("r5_rst_out_valid", out_valid, 0);
    chk("r5_rst_ovf", ovf, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("r5_post_valid", out_valid, 0);
    chk("r5_post_ready", ready, 0);
    begin_run(1);
    valid = 1'b1;
    drive(7); step();
    valid = 1'b0;
    chk("r5_out_valid", out_valid, 1);
    chk("r5_acc", acc, 7);
    consume();

    // zero-length run
    valid = 1'b1;
    drive(5);
    begin_run(0);
    chk("r6_out_valid", out_valid, 1);
    chk("r6_acc", acc, 0);
    chk("r6_ready", ready, 0);
    step();
    valid = 1'b0;
    chk("r6_acc_hold", acc, 0);
    consume();
    chk("r6_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
